mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one arbiter that shares the single 128-bit memory port between the instruction-cache refill port and the data-side memory port, which carries both cachable line traffic and uncachable device traffic. It sits between the two cache memory ports and the uni-to-AXI bridge. Each request is latched at grant and replayed downstream from registers. Requesters alternate round-robin when both are pending, and the data side gets priority during a cache clean.

## Interface
- ADDR_W, 32, address width
- DATA_W, 128, memory data width
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  reset, asynchronous, active-low
- i_clean  in  1  dCache clean in progress; forces data-side priority
- i_imem_valid  in  1  iCache request (read only)
- i_imem_addr  in  ADDR_W  iCache address
- i_imem_size  in  3  iCache size code
- i_imem_cachable  in  1  iCache cachable flag
- o_imem_ready  out  1  iCache completion pulse
- o_imem_rdata  out  DATA_W  iCache read data, valid with o_imem_ready
- i_dmem_valid  in  1  data-side request
- i_dmem_reqtyp  in  1  0 = read, 1 = write
- i_dmem_addr  in  ADDR_W  data-side address
- i_dmem_wdata  in  DATA_W  data-side write data
- i_dmem_size  in  3  data-side size code
- i_dmem_cachable  in  1  data-side cachable flag
- o_dmem_ready  out  1  data-side completion pulse
- o_dmem_rdata  out  DATA_W  data-side read data
- o_mem_valid, o_mem_reqtyp, o_mem_addr, o_mem_wdata, o_mem_size, o_mem_cachable  out  1/1/ADDR_W/DATA_W/3/1  downstream request, all registered
- i_mem_ready  in  1  downstream completion pulse
- i_mem_rdata  in  DATA_W  downstream read data

## Operation
- States:
  - IDLE: no grant held.
  - GNT_I: iCache holds the port.
  - GNT_D: data side holds the port.
- Round-robin pointer last_d: 1 = last grant went to the data side. Reset value 0, so the data side wins the first tie.
- Grant decision, evaluated only in IDLE:
  - Only one valid: grant that requester.
  - Both valid with i_clean = 1: grant data side.
  - Both valid with i_clean = 0: grant iCache if last_d = 1, else data side.
  - No valid: stay in IDLE.
- On grant, the same edge does all of the following:
  - Latch the winner's attributes into the o_mem_* registers.
  - For an iCache grant, force o_mem_reqtyp = 0 and o_mem_wdata = 0.
  - Set o_mem_valid = 1.
  - Update last_d.
  - Move to GNT_x.
- In GNT_x:
  - o_mem_* hold stable and requester inputs are ignored.
  - i_mem_ready = 1: o_x_ready = 1 combinationally in that cycle, o_x_rdata = i_mem_rdata, the non-granted ready stays 0, o_mem_valid clears and the state returns to IDLE on the next edge.
- o_imem_rdata and o_dmem_rdata pass i_mem_rdata through at all times; they are meaningful only with the matching ready.
- i_mem_ready in IDLE is ignored: no ready goes to either requester.
- A requester that drops valid while granted has no effect; the latched transaction completes and its ready pulse is still delivered.
- i_clean changes take effect at the next IDLE decision, never during a grant.

## Timing
- Reset, asynchronous: state = IDLE, last_d = 0, all o_mem_* = 0. o_imem_ready = o_dmem_ready = 0, because they are gated by state.
- Arbitration latency: request valid at edge N in IDLE -> o_mem_valid = 1 after edge N.
- Completion: i_mem_ready at cycle M -> requester ready in cycle M -> IDLE after edge M -> a new grant is possible at edge M+1 -> downstream valid from cycle M+2.
- A requester holding valid after seeing its ready is treated as a new request at M+1.
- Reset asserted mid-transaction: the grant is abandoned immediately and no ready pulse is issued. Downstream shares the same reset.
- At most one transaction is outstanding; no pipelining.

## Test plan
- Lone iCache read, addr 0x8000_0040: o_mem_valid rises 1 cycle later with reqtyp = 0, addr 0x8000_0040. Downstream ready 3 cycles later with rdata 0x1234...: o_imem_ready = 1 with that rdata, o_dmem_ready stays 0.
- Simultaneous i/d valid after reset: data side granted first. Both held valid -> grants go D, I, D, I across four transactions.
- i_clean = 1 with both valid over three transactions: the data side wins every time. iCache is granted only after i_clean drops or the data side goes idle.
- Data-side write, addr 0x1000_0000, wdata 0xAB, cachable = 0: the downstream fields match exactly. Changing i_dmem_addr mid-grant leaves o_mem_addr unchanged.
- Assert i_rst_n low while in GNT_D before ready: all outputs are 0 immediately, and no ready pulse follows after reset release.
- i_mem_ready pulsed while IDLE: no requester ready and the state is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-to-one round-robin arbiter sharing one 128-bit memory port between the
// iCache refill port and the data-side port; grants are latched and replayed from registers.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clean,

  input  logic              i_imem_valid,
  input  logic [ADDR_W-1:0] i_imem_addr,
  input  logic [2:0]        i_imem_size,
  input  logic              i_imem_cachable,
  output logic              o_imem_ready,
  output logic [DATA_W-1:0] o_imem_rdata,

  input  logic              i_dmem_valid,
  input  logic              i_dmem_reqtyp,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic [DATA_W-1:0] i_dmem_wdata,
  input  logic [2:0]        i_dmem_size,
  input  logic              i_dmem_cachable,
  output logic              o_dmem_ready,
  output logic [DATA_W-1:0] o_dmem_rdata,

  output logic              o_mem_valid,
  output logic              o_mem_reqtyp,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_size,
  output logic              o_mem_cachable,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_d;
  logic   pick_i;
  logic   pick_d;

  // Data side wins when alone, during a clean, or when it is its turn.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (i_dmem_valid && (!i_imem_valid || i_clean || !last_d)) begin
      pick_d = 1'b1;
    end else if (i_imem_valid) begin
      pick_i = 1'b1;
    end
  end

  // Readies are gated by state so a stray downstream ready in IDLE goes nowhere.
  assign o_imem_ready = (state == GNT_I) && i_mem_ready;
  assign o_dmem_ready = (state == GNT_D) && i_mem_ready;
  assign o_imem_rdata = i_mem_rdata;
  assign o_dmem_rdata = i_mem_rdata;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      last_d         <= 1'b0;
      o_mem_valid    <= 1'b0;
      o_mem_reqtyp   <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_mem_size     <= '0;
      o_mem_cachable <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state          <= GNT_D;
            last_d         <= 1'b1;
            o_mem_valid    <= 1'b1;
            o_mem_reqtyp   <= i_dmem_reqtyp;
            o_mem_addr     <= i_dmem_addr;
            o_mem_wdata    <= i_dmem_wdata;
            o_mem_size     <= i_dmem_size;
            o_mem_cachable <= i_dmem_cachable;
          end else if (pick_i) begin
            state          <= GNT_I;
            last_d         <= 1'b0;
            o_mem_valid    <= 1'b1;
            o_mem_reqtyp   <= 1'b0;
            o_mem_addr     <= i_imem_addr;
            o_mem_wdata    <= '0;
            o_mem_size     <= i_imem_size;
            o_mem_cachable <= i_imem_cachable;
          end
        end
        GNT_I, GNT_D: begin
          // Requester inputs are ignored until the downstream completes.
          if (i_mem_ready) begin
            state       <= IDLE;
            o_mem_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          o_mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clean;
  logic              imem_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [2:0]        imem_size;
  logic              imem_cachable;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_valid;
  logic              dmem_reqtyp;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [2:0]        dmem_size;
  logic              dmem_cachable;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;
  logic              mem_valid;
  logic              mem_reqtyp;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_size;
  logic              mem_cachable;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_clean         (clean),
    .i_imem_valid    (imem_valid),
    .i_imem_addr     (imem_addr),
    .i_imem_size     (imem_size),
    .i_imem_cachable (imem_cachable),
    .o_imem_ready    (imem_ready),
    .o_imem_rdata    (imem_rdata),
    .i_dmem_valid    (dmem_valid),
    .i_dmem_reqtyp   (dmem_reqtyp),
    .i_dmem_addr     (dmem_addr),
    .i_dmem_wdata    (dmem_wdata),
    .i_dmem_size     (dmem_size),
    .i_dmem_cachable (dmem_cachable),
    .o_dmem_ready    (dmem_ready),
    .o_dmem_rdata    (dmem_rdata),
    .o_mem_valid     (mem_valid),
    .o_mem_reqtyp    (mem_reqtyp),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .o_mem_size      (mem_size),
    .o_mem_cachable  (mem_cachable),
    .i_mem_ready     (mem_ready),
    .i_mem_rdata     (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port (none / icache / data) and the held transaction.
  typedef enum int {OWN_NONE, OWN_I, OWN_D} owner_t;
  typedef struct {
    logic              valid;
    logic              reqtyp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        size;
    logic              cachable;
  } txn_t;

  owner_t m_owner;
  bit     m_last_was_d;
  txn_t   m_txn;

  function automatic void model_reset();
    m_owner      = OWN_NONE;
    m_last_was_d = 1'b0;
    m_txn        = '{valid: 1'b0, reqtyp: 1'b0, addr: '0, wdata: '0, size: '0, cachable: 1'b0};
  endfunction

  function automatic void model_edge();
    owner_t winner;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner != OWN_NONE) begin
      if (mem_ready) begin
        m_owner     = OWN_NONE;
        m_txn.valid = 1'b0;
      end
      return;
    end
    if (!imem_valid && !dmem_valid) return;
    if (imem_valid && dmem_valid) winner = (clean || !m_last_was_d) ? OWN_D : OWN_I;
    else winner = dmem_valid ? OWN_D : OWN_I;
    m_owner      = winner;
    m_last_was_d = (winner == OWN_D);
    if (winner == OWN_D)
      m_txn = '{valid: 1'b1, reqtyp: dmem_reqtyp, addr: dmem_addr, wdata: dmem_wdata,
                size: dmem_size, cachable: dmem_cachable};
    else
      m_txn = '{valid: 1'b1, reqtyp: 1'b0, addr: imem_addr, wdata: '0,
                size: imem_size, cachable: imem_cachable};
  endfunction

  // Inputs are set at the negedge by the caller; compare mid-cycle, then advance the model at the edge.
  task automatic cycle();
    #1;
    if (!rst_n) model_reset();
    check("imem_ready", imem_ready, rst_n && m_owner == OWN_I && mem_ready);
    check("dmem_ready", dmem_ready, rst_n && m_owner == OWN_D && mem_ready);
    check("imem_rdata", imem_rdata, mem_rdata);
    check("dmem_rdata", dmem_rdata, mem_rdata);
    check("mem_valid", mem_valid, m_txn.valid);
    check("mem_reqtyp", mem_reqtyp, m_txn.reqtyp);
    check("mem_addr", mem_addr, m_txn.addr);
    check("mem_wdata", mem_wdata, m_txn.wdata);
    check("mem_size", mem_size, m_txn.size);
    check("mem_cachable", mem_cachable, m_txn.cachable);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clean = 0; imem_valid = 0; imem_addr = '0; imem_size = '0; imem_cachable = 0;
    dmem_valid = 0; dmem_reqtyp = 0; dmem_addr = '0; dmem_wdata = '0; dmem_size = '0;
    dmem_cachable = 0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    cycle();
    cycle();
    rst_n = 1;
  endtask

  task automatic complete(input logic [DATA_W-1:0] rdata);
    mem_ready = 1;
    mem_rdata = rdata;
    cycle();
    mem_ready = 0;
  endtask

  logic [DATA_W-1:0] rd_pattern;
  logic [ADDR_W-1:0] exp_seq [4];

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Lone iCache read with a three-cycle downstream latency.
    imem_valid = 1; imem_addr = 32'h8000_0040; imem_size = 3'd4; imem_cachable = 1;
    cycle();
    imem_valid = 0;
    check("lone_i_valid", mem_valid, 1'b1);
    check("lone_i_addr", mem_addr, 32'h8000_0040);
    check("lone_i_reqtyp", mem_reqtyp, 1'b0);
    cycle(); cycle();
    rd_pattern = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    mem_ready = 1; mem_rdata = rd_pattern;
    #1;
    check("lone_i_ready", imem_ready, 1'b1);
    check("lone_i_rdata", imem_rdata, rd_pattern);
    check("lone_i_dready", dmem_ready, 1'b0);
    complete(rd_pattern);

    // Both held valid after reset: grants alternate D, I, D, I.
    do_reset();
    exp_seq = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0200, 32'h0000_0100};
    imem_valid = 1; imem_addr = 32'h0000_0100;
    dmem_valid = 1; dmem_addr = 32'h0000_0200; dmem_wdata = 128'h55;
    for (int t = 0; t < 4; t++) begin
      cycle();
      check($sformatf("rr_grant%0d", t), mem_addr, exp_seq[t]);
      complete(128'(t));
    end

    // Clean forces data-side priority; iCache wins once clean drops.
    clean = 1;
    for (int t = 0; t < 3; t++) begin
      cycle();
      check($sformatf("clean_grant%0d", t), mem_addr, 32'h0000_0200);
      complete(128'(t + 10));
    end
    clean = 0;
    cycle();
    check("after_clean_grant", mem_addr, 32'h0000_0100);
    complete(128'hC0);
    imem_valid = 0; dmem_valid = 0;
    cycle();

    // Data-side uncachable write; address changes mid-grant are ignored.
    dmem_valid = 1; dmem_reqtyp = 1; dmem_addr = 32'h1000_0000; dmem_wdata = 128'hAB;
    dmem_size = 3'd2; dmem_cachable = 0;
    cycle();
    dmem_addr = 32'h2222_0000;
    check("wr_reqtyp", mem_reqtyp, 1'b1);
    check("wr_wdata", mem_wdata, 128'hAB);
    cycle();
    check("wr_addr_held", mem_addr, 32'h1000_0000);
    dmem_valid = 0;
    complete('0);

    // Reset during GNT_D abandons the grant with no ready afterwards.
    dmem_valid = 1; dmem_reqtyp = 0; dmem_addr = 32'h3000_0000;
    cycle();
    dmem_valid = 0;
    cycle();
    rst_n = 0; mem_ready = 1;
    #1;
    check("rst_mid_valid", mem_valid, 1'b0);
    check("rst_mid_addr", mem_addr, '0);
    check("rst_mid_dready", dmem_ready, 1'b0);
    cycle();
    rst_n = 1;
    cycle();
    check("rst_after_dready", dmem_ready, 1'b0);

    // Downstream ready while IDLE is ignored.
    mem_ready = 1;
    #1;
    check("idle_ready_i", imem_ready, 1'b0);
    check("idle_ready_d", dmem_ready, 1'b0);
    cycle();
    mem_ready = 0;
    check("idle_ready_state", mem_valid, 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      clean         = ($urandom_range(0, 3) == 0);
      imem_valid    = ($urandom_range(0, 1) == 1);
      imem_addr     = $urandom;
      imem_size     = 3'($urandom_range(0, 7));
      imem_cachable = 1'($urandom_range(0, 1));
      dmem_valid    = ($urandom_range(0, 1) == 1);
      dmem_reqtyp   = 1'($urandom_range(0, 1));
      dmem_addr     = $urandom;
      dmem_wdata    = {$urandom, $urandom, $urandom, $urandom};
      dmem_size     = 3'($urandom_range(0, 7));
      dmem_cachable = 1'($urandom_range(0, 1));
      mem_ready     = ($urandom_range(0, 2) == 0);
      mem_rdata     = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
